// File: rtl/bcd_seg_pkg.sv
// Shared types and constants for the BCD seven-segment scanner.
// Segment patterns are active-high, bit 6..0 = g..a.
package bcd_seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LATCH
    } state_t;

    localparam int CONV_STEPS = 7;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [3:0] DIGIT_ERR = 4'hF;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to active-high seven-segment pattern.
// The error digit decodes to a dash; unused codes decode to all-off.
module bcd_seg_decode
    import bcd_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_ah
);

    always_comb begin
        seg_ah = SEG_OFF;
        case (digit)
            4'd0:      seg_ah = SEG_0;
            4'd1:      seg_ah = SEG_1;
            4'd2:      seg_ah = SEG_2;
            4'd3:      seg_ah = SEG_3;
            4'd4:      seg_ah = SEG_4;
            4'd5:      seg_ah = SEG_5;
            4'd6:      seg_ah = SEG_6;
            4'd7:      seg_ah = SEG_7;
            4'd8:      seg_ah = SEG_8;
            4'd9:      seg_ah = SEG_9;
            DIGIT_ERR: seg_ah = SEG_DASH;
            default:   seg_ah = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Binary-to-BCD conversion (sequential double dabble) feeding a two-digit
// multiplexed seven-segment display with blanking and blinking.
module bcd_seg_scanner
    import bcd_seg_pkg::*;
#(
    parameter int CLK_DIV    = 50000,
    parameter int BLINK_DIV  = 250,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] value_in,
    input  logic       load,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic       busy,
    output logic       valid,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_t          state, state_nxt;
    logic [6:0]      bin_q;
    logic [7:0]      acc_q;
    logic [2:0]      iter_q;
    logic            range_err_q;
    logic            valid_q;
    logic [3:0]      tens_q, ones_q;

    logic [PW-1:0]   presc_q;
    logic            tick;
    logic            sel_q;
    logic [BW-1:0]   blink_cnt_q;
    logic            phase_q;

    logic [3:0]      digit_sel;
    logic [6:0]      dec_seg;
    logic [6:0]      seg_src;
    logic [6:0]      seg_p1;
    logic [1:0]      an_p1;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [7:0] dabble_adj(input logic [7:0] acc);
        logic [3:0] hi, lo;
        hi = acc[7:4];
        lo = acc[3:0];
        if (hi >= 4'd5) hi = hi + 4'd3;
        if (lo >= 4'd5) lo = lo + 4'd3;
        return {hi, lo};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = CONV;
            CONV:    if (iter_q == 3'(CONV_STEPS - 1)) state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q       <= '0;
            acc_q       <= '0;
            iter_q      <= '0;
            range_err_q <= 1'b0;
            valid_q     <= 1'b0;
            tens_q      <= '0;
            ones_q      <= '0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    bin_q       <= value_in;
                    acc_q       <= '0;
                    iter_q      <= '0;
                    range_err_q <= (value_in > 7'd99);
                end
                CONV: begin
                    {acc_q, bin_q} <= {dabble_adj(acc_q), bin_q} << 1;
                    iter_q         <= iter_q + 3'd1;
                end
                LATCH: begin
                    valid_q <= 1'b1;
                    tens_q  <= range_err_q ? DIGIT_ERR : acc_q[7:4];
                    ones_q  <= range_err_q ? DIGIT_ERR : acc_q[3:0];
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign valid    = valid_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;

    // Scan prescaler, digit select and free-running blink phase.
    assign tick = (presc_q == PW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            sel_q       <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                sel_q <= ~sel_q;
                if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BW'(1);
                end
            end
        end
    end

    assign digit_sel = sel_q ? tens_q : ones_q;

    bcd_seg_decode u_decode (
        .digit  (digit_sel),
        .seg_ah (dec_seg)
    );

    always_comb begin
        seg_src = dec_seg;
        if (!valid_q)                                   seg_src = SEG_OFF;
        else if (blink_en && phase_q)                   seg_src = SEG_OFF;
        else if (digit_sel == DIGIT_ERR)                seg_src = SEG_DASH;
        else if (sel_q && blank_lz && tens_q == 4'd0)   seg_src = SEG_OFF;
    end

    // Output register stage; polarity is a constant inversion on the way out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_p1 <= SEG_OFF;
            an_p1  <= 2'b01;
        end else begin
            seg_p1 <= seg_src;
            an_p1  <= sel_q ? 2'b10 : 2'b01;
        end
    end

    assign seg = ACTIVE_LOW ? ~seg_p1 : seg_p1;
    assign an  = ACTIVE_LOW ? ~an_p1  : an_p1;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Scoreboard bench for bcd_seg_scanner with a fast scan (CLK_DIV=4,
// BLINK_DIV=2) and active-low outputs.
module tb_bcd_seg_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] value_in;
    logic       load;
    logic       blank_lz;
    logic       blink_en;
    logic       busy;
    logic       valid;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [6:0] seg;
    logic [1:0] an;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb[$];

    // Active-low patterns for digits 0..9 (bit 6..0 = g..a).
    localparam logic [6:0] SEG_AL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    bcd_seg_scanner #(
        .CLK_DIV    (4),
        .BLINK_DIV  (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .load     (load),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .busy     (busy),
        .valid    (valid),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_digits(input logic [6:0] v);
        int t, o;
        if (v > 7'd99) return 8'hFF;
        t = int'(v) / 10;
        o = int'(v) % 10;
        return {4'(t), 4'(o)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        if (d == 4'hF) return 7'h3F;
        if (d < 4'd10) return SEG_AL[d];
        return 7'h7F;
    endfunction

    // Caller is at a negedge. inj_at >= 0 raises a second load after edge k+inj_at.
    task automatic do_load(input string name, input logic [6:0] v,
                           input int inj_at, input logic [6:0] inj_v);
        logic [7:0] exp;
        value_in = v;
        load = 1'b1;
        sb.push_back(model_digits(v));
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s busy[k+%0d]: got %b want 1", name, i, busy);
            end
            load = 1'b0;
            if (i == inj_at) begin
                value_in = inj_v;
                load = 1'b1;
            end
            @(negedge clk);
        end
        load = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done: got busy=%b valid=%b want busy=0 valid=1", name, busy, valid);
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s scoreboard empty at completion", name);
        end else begin
            exp = sb.pop_front();
            if ({bcd_tens, bcd_ones} !== exp) begin
                n_bad++;
                $display("FAIL %s digits: got %h/%h want %h/%h", name, bcd_tens, bcd_ones, exp[7:4], exp[3:0]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s no_restart: got busy=%b want 0", name, busy);
        end
    endtask

    task automatic test_scan(input string name, input logic [3:0] t, input logic [3:0] o,
                             input logic blank);
        logic [6:0] exp_t;
        bit seen_t, seen_o;
        exp_t = (blank && t == 4'd0) ? 7'h7F : seg_of(t);
        seen_t = 0;
        seen_o = 0;
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (an == 2'b10) begin
                seen_o = 1;
                if (seg !== seg_of(o)) begin
                    n_bad++;
                    $display("FAIL %s ones_seg: got %h want %h", name, seg, seg_of(o));
                end
            end else if (an == 2'b01) begin
                seen_t = 1;
                if (seg !== exp_t) begin
                    n_bad++;
                    $display("FAIL %s tens_seg: got %h want %h", name, seg, exp_t);
                end
            end else begin
                n_bad++;
                $display("FAIL %s an_onehot: got %b want 10 or 01", name, an);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!(seen_t && seen_o)) begin
            n_bad++;
            $display("FAIL %s both_slots: got tens=%0d ones=%0d want 1 1", name, seen_t, seen_o);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load = 1'b0;
        value_in = '0;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (seg !== 7'h7F || an !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_disp: got seg=%h an=%b want 7f 10", seg, an);
        end
        n_cmp++;
        if (busy !== 1'b0 || valid !== 1'b0 || bcd_tens !== 4'd0 || bcd_ones !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_ctl: got busy=%b valid=%b digits=%h/%h want 0 0 0/0",
                     busy, valid, bcd_tens, bcd_ones);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (seg !== 7'h7F) begin
                n_bad++;
                $display("FAIL reset_blank: got seg=%h want 7f", seg);
            end
        end
    endtask

    task automatic test_scan_period();
        logic [1:0] prev;
        int waited;
        prev = an;
        waited = 0;
        while (an === prev && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (an === prev) begin
            n_bad++;
            $display("FAIL scan_toggle: got an stuck at %b want change within 8", an);
        end
        for (int r = 0; r < 2; r++) begin
            prev = an;
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                n_cmp++;
                if ((i < 4 && an !== prev) || (i == 4 && an !== ~prev)) begin
                    n_bad++;
                    $display("FAIL scan_period[%0d]: got an=%b prev=%b", i, an, prev);
                end
            end
        end
    endtask

    task automatic test_basic();
        do_load("load57", 7'd57, -1, 7'd0);
        test_scan("scan57", 4'd5, 4'd7, 1'b0);
        test_scan_period();
    endtask

    task automatic test_blank_lz();
        blank_lz = 1'b1;
        do_load("load7", 7'd7, -1, 7'd0);
        test_scan("blank_on", 4'd0, 4'd7, 1'b1);
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        test_scan("blank_off", 4'd0, 4'd7, 1'b0);
    endtask

    task automatic test_boundary();
        do_load("load0", 7'd0, -1, 7'd0);
        test_scan("scan0", 4'd0, 4'd0, 1'b0);
        do_load("load99", 7'd99, -1, 7'd0);
        test_scan("scan99", 4'd9, 4'd9, 1'b0);
        do_load("load120", 7'd120, -1, 7'd0);
        test_scan("scan120", 4'hF, 4'hF, 1'b0);
        do_load("load100", 7'd100, -1, 7'd0);
        do_load("load127", 7'd127, -1, 7'd0);
    endtask

    task automatic test_busy_ignore();
        do_load("load42", 7'd42, 2, 7'd13);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || bcd_tens !== 4'd4 || bcd_ones !== 4'd2) begin
                n_bad++;
                $display("FAIL busy_ignore: got busy=%b digits=%h/%h want 0 4/2", busy, bcd_tens, bcd_ones);
            end
        end
        do_load("load13", 7'd13, -1, 7'd0);
        test_scan("scan13", 4'd1, 4'd3, 1'b0);
        do_load("latch_ign", 7'd61, 7, 7'd25);
    endtask

    task automatic test_back_to_back();
        do_load("b2b_a", 7'd38, -1, 7'd0);
        do_load("b2b_b", 7'd64, -1, 7'd0);
    endtask

    task automatic test_blink();
        logic [6:0] prev;
        int waited;
        do_load("load88", 7'd88, -1, 7'd0);
        blink_en = 1'b1;
        repeat (20) @(negedge clk);
        prev = seg;
        waited = 0;
        @(negedge clk);
        while (!(prev !== 7'h7F && seg === 7'h7F) && waited < 24) begin
            prev = seg;
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (seg !== 7'h7F) begin
            n_bad++;
            $display("FAIL blink_edge: got seg=%h want 7f within 24", seg);
        end
        for (int i = 0; i < 17; i++) begin
            n_cmp++;
            if ((i < 8 || i == 16) ? (seg !== 7'h7F) : (seg !== 7'h00)) begin
                n_bad++;
                $display("FAIL blink[%0d]: got seg=%h want %h", i, seg,
                         (i < 8 || i == 16) ? 7'h7F : 7'h00);
            end
            @(negedge clk);
        end
        blink_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_conv();
        value_in = 7'd33;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || valid !== 1'b0 || seg !== 7'h7F || an !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_mid: got busy=%b valid=%b seg=%h an=%b want 0 0 7f 10",
                     busy, valid, seg, an);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || seg !== 7'h7F) begin
                n_bad++;
                $display("FAIL reset_mid_after: got busy=%b seg=%h want 0 7f", busy, seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank_lz();
        test_boundary();
        test_busy_ignore();
        test_back_to_back();
        test_blink();
        test_reset_mid_conv();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_left: got %0d entries want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
